// File: rtl/cpu_imem_pkg.sv
// Shared types for the instruction-memory arbiter: FSM states, transaction
// owner and the memory command carried through each pending slot.
package cpu_imem_pkg;

  // Widest address any instance may use; narrower instances zero-extend.
  localparam int unsigned ADDR_W_MAX = 64;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPUI = 2'd1,
    OWN_LDR  = 2'd2
  } owner_e;

  typedef struct packed {
    logic                  write;
    logic [ADDR_W_MAX-1:0] addr;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;
  } mem_cmd_t;

endpackage

// File: rtl/cpu_imem_arb_if.sv
// Bus bundle for the instruction-memory arbiter: CPU fetch port, loader port
// and the single instruction-memory port. "slave" is the arbiter's view,
// "master" is the environment's view.
interface cpu_imem_arb_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              cpui_request;
  logic [ADDR_W-1:0] cpui_addr;
  logic [31:0]       cpui_rdata;
  logic              cpui_ack;

  logic              ldr_request;
  logic              ldr_write;
  logic [ADDR_W-1:0] ldr_addr;
  logic [31:0]       ldr_wdata;
  logic [3:0]        ldr_wstrb;
  logic [31:0]       ldr_rdata;
  logic              ldr_ack;

  logic              mem_request;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wstrb;
  logic [31:0]       mem_rdata;
  logic              mem_ack;

  logic              proto_err;

  modport slave (
    input  cpui_request, cpui_addr,
    output cpui_rdata, cpui_ack,
    input  ldr_request, ldr_write, ldr_addr, ldr_wdata, ldr_wstrb,
    output ldr_rdata, ldr_ack,
    output mem_request, mem_write, mem_addr, mem_wdata, mem_wstrb,
    input  mem_rdata, mem_ack,
    output proto_err
  );

  modport master (
    output cpui_request, cpui_addr,
    input  cpui_rdata, cpui_ack,
    output ldr_request, ldr_write, ldr_addr, ldr_wdata, ldr_wstrb,
    input  ldr_rdata, ldr_ack,
    input  mem_request, mem_write, mem_addr, mem_wdata, mem_wstrb,
    output mem_rdata, mem_ack,
    input  proto_err
  );
endinterface

// File: rtl/cpu_imem_slot.sv
// One-entry pending slot for a requester. A request latches its command; the
// owner's ack clears it. A request arriving in the same cycle as the clear
// is accepted as the next entry; a request into an occupied slot is dropped
// and flagged as overflow.
module cpu_imem_slot
  import cpu_imem_pkg::*;
(
  input  logic     clock,
  input  logic     reset,
  input  logic     request,
  input  logic     clear,
  input  mem_cmd_t cmd_in,
  output logic     occupied,
  output mem_cmd_t cmd,
  output logic     overflow
);

  // Latch on request when free (or being freed), otherwise clear on ack.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      occupied <= 1'b0;
      cmd      <= '0;
    end else if (request && (!occupied || clear)) begin
      occupied <= 1'b1;
      cmd      <= cmd_in;
    end else if (clear) begin
      occupied <= 1'b0;
    end
  end

  assign overflow = request && occupied && !clear;

endmodule

// File: rtl/cpu_imem_arb.sv
// Instruction-memory arbiter between the CPU fetch port and a loader/debug
// port, with one memory transaction outstanding at a time.
// Optional build macro CPU_IMEM_ARB_RR_EN: resolve ties round-robin instead
// of fixed CPU priority.
module cpu_imem_arb
  import cpu_imem_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input logic           clock,
  input logic           reset,
  cpu_imem_arb_if.slave bus
);

  state_e   state;
  owner_e   owner;
  owner_e   grant_owner;
  mem_cmd_t cpui_cmd_in, ldr_cmd_in;
  mem_cmd_t cpui_cmd_q, ldr_cmd_q;
  mem_cmd_t grant_cmd;
  logic     cpui_occ, ldr_occ;
  logic     cpui_ovf, ldr_ovf;
  logic     cpui_want, ldr_want, pick_cpui;
  logic     mem_done, cpui_done, ldr_done;
  logic     proto_err;

  logic              mem_request, mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wstrb;

  // Incoming commands; CPU fetches are always reads with no byte enables.
  always_comb begin
    cpui_cmd_in       = '0;
    cpui_cmd_in.addr  = ADDR_W_MAX'(bus.cpui_addr);
    ldr_cmd_in        = '0;
    ldr_cmd_in.write  = bus.ldr_write;
    ldr_cmd_in.addr   = ADDR_W_MAX'(bus.ldr_addr);
    ldr_cmd_in.wdata  = bus.ldr_wdata;
    ldr_cmd_in.wstrb  = bus.ldr_wstrb;
  end

  // A completion only counts while a transaction is actually outstanding.
  assign mem_done  = (state == ST_BUSY) && bus.mem_ack;
  assign cpui_done = mem_done && (owner == OWN_CPUI);
  assign ldr_done  = mem_done && (owner == OWN_LDR);

  cpu_imem_slot u_cpui_slot (
    .clock    (clock),
    .reset    (reset),
    .request  (bus.cpui_request),
    .clear    (cpui_done),
    .cmd_in   (cpui_cmd_in),
    .occupied (cpui_occ),
    .cmd      (cpui_cmd_q),
    .overflow (cpui_ovf)
  );

  cpu_imem_slot u_ldr_slot (
    .clock    (clock),
    .reset    (reset),
    .request  (bus.ldr_request),
    .clear    (ldr_done),
    .cmd_in   (ldr_cmd_in),
    .occupied (ldr_occ),
    .cmd      (ldr_cmd_q),
    .overflow (ldr_ovf)
  );

  assign cpui_want = cpui_occ || bus.cpui_request;
  assign ldr_want  = ldr_occ  || bus.ldr_request;

`ifdef CPU_IMEM_ARB_RR_EN
  owner_e last_served;

  // Remember who was granted last so the other side wins the next tie.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_served <= OWN_LDR;
    end else if (state == ST_IDLE && grant_owner != OWN_NONE) begin
      last_served <= grant_owner;
    end
  end

  assign pick_cpui = cpui_want && (!ldr_want || last_served == OWN_LDR);
`else
  assign pick_cpui = cpui_want;
`endif

  // Winner selection; a pulse arriving this cycle is used directly since its
  // slot only captures it at the coming edge.
  always_comb begin
    grant_owner = OWN_NONE;
    grant_cmd   = '0;
    if (pick_cpui) begin
      grant_owner = OWN_CPUI;
      grant_cmd   = cpui_occ ? cpui_cmd_q : cpui_cmd_in;
    end else if (ldr_want) begin
      grant_owner = OWN_LDR;
      grant_cmd   = ldr_occ ? ldr_cmd_q : ldr_cmd_in;
    end
  end

  // Address bits above ADDR_W are always zero in the slot commands.
  logic unused_addr_hi;
  assign unused_addr_hi = ^grant_cmd.addr;

  // Arbiter FSM with registered memory command outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      owner       <= OWN_NONE;
      mem_request <= 1'b0;
      mem_write   <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_wstrb   <= '0;
    end else begin
      mem_request <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_owner != OWN_NONE) begin
            mem_request <= 1'b1;
            mem_write   <= grant_cmd.write;
            mem_addr    <= grant_cmd.addr[ADDR_W-1:0];
            mem_wdata   <= grant_cmd.wdata;
            mem_wstrb   <= grant_cmd.wstrb;
            owner       <= grant_owner;
            state       <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (bus.mem_ack) begin
            owner <= OWN_NONE;
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  // Sticky protocol error on any dropped request.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      proto_err <= 1'b0;
    end else if (cpui_ovf || ldr_ovf) begin
      proto_err <= 1'b1;
    end
  end

  assign bus.cpui_ack    = cpui_done;
  assign bus.cpui_rdata  = cpui_done ? bus.mem_rdata : '0;
  assign bus.ldr_ack     = ldr_done;
  assign bus.ldr_rdata   = ldr_done ? bus.mem_rdata : '0;
  assign bus.mem_request = mem_request;
  assign bus.mem_write   = mem_write;
  assign bus.mem_addr    = mem_addr;
  assign bus.mem_wdata   = mem_wdata;
  assign bus.mem_wstrb   = mem_wstrb;
  assign bus.proto_err   = proto_err;

endmodule

// File: tb/tb_cpu_imem_arb.sv
// Directed bench for cpu_imem_arb with a behavioural memory that answers a
// fixed number of cycles after each mem_request.
module tb_cpu_imem_arb;

  logic clock;
  logic reset;

  int unsigned checks;
  int unsigned errors;
  int unsigned mem_delay;

  logic        rsp_pend;
  int unsigned rsp_cnt;
  logic [31:0] rsp_addr;

  cpu_imem_arb_if #(.ADDR_W(32)) bus ();

  cpu_imem_arb #(.ADDR_W(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory contents: a simple address-derived pattern (0x100 -> 0xDEADBEEF).
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return addr ^ 32'hDEADBFEF;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Memory responder: acks mem_delay cycles after seeing mem_request.
  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    rsp_pend      = 1'b0;
    rsp_cnt       = 0;
    rsp_addr      = '0;
    forever begin
      @(posedge clock);
      #1;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;
      if (rsp_pend) begin
        if (rsp_cnt == 0) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = mem_word(rsp_addr);
          rsp_pend      = 1'b0;
        end else begin
          rsp_cnt--;
        end
      end
      if (bus.mem_request) begin
        rsp_pend = 1'b1;
        rsp_addr = bus.mem_addr;
        rsp_cnt  = mem_delay - 1;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int unsigned n_c, n_l, n_req, first;
    logic        seen;

    checks = 0;
    errors = 0;
    mem_delay = 1;
    reset = 1'b0;
    bus.cpui_request = 1'b0;
    bus.cpui_addr    = '0;
    bus.ldr_request  = 1'b0;
    bus.ldr_write    = 1'b0;
    bus.ldr_addr     = '0;
    bus.ldr_wdata    = '0;
    bus.ldr_wstrb    = '0;

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_mem_request", 32'(bus.mem_request), 32'h0);
    check("rst_cpui_ack", 32'(bus.cpui_ack), 32'h0);
    check("rst_ldr_ack", 32'(bus.ldr_ack), 32'h0);
    check("rst_proto_err", 32'(bus.proto_err), 32'h0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    reset = 1'b1;
    @(negedge clock);

    // CPU fetch, one-cycle memory
    bus.cpui_request = 1'b1;
    bus.cpui_addr    = 32'h100;
    @(negedge clock);
    bus.cpui_request = 1'b0;
    check("fetch_mem_request", 32'(bus.mem_request), 32'h1);
    check("fetch_mem_addr", bus.mem_addr, 32'h100);
    check("fetch_mem_write", 32'(bus.mem_write), 32'h0);
    check("fetch_mem_wstrb", 32'(bus.mem_wstrb), 32'h0);
    check("fetch_no_early_ack", 32'(bus.cpui_ack), 32'h0);
    @(negedge clock);
    check("fetch_cpui_ack", 32'(bus.cpui_ack), 32'h1);
    check("fetch_cpui_rdata", bus.cpui_rdata, 32'hDEADBEEF);
    check("fetch_ldr_ack", 32'(bus.ldr_ack), 32'h0);
    check("fetch_ldr_rdata", bus.ldr_rdata, 32'h0);
    @(negedge clock);
    check("fetch_ack_pulse", 32'(bus.cpui_ack), 32'h0);
    check("fetch_rdata_zero", bus.cpui_rdata, 32'h0);

    // Loader write
    bus.ldr_request = 1'b1;
    bus.ldr_write   = 1'b1;
    bus.ldr_addr    = 32'h40;
    bus.ldr_wdata   = 32'h12345678;
    bus.ldr_wstrb   = 4'hF;
    @(negedge clock);
    bus.ldr_request = 1'b0;
    check("lwr_mem_request", 32'(bus.mem_request), 32'h1);
    check("lwr_mem_write", 32'(bus.mem_write), 32'h1);
    check("lwr_mem_wstrb", 32'(bus.mem_wstrb), 32'hF);
    check("lwr_mem_addr", bus.mem_addr, 32'h40);
    check("lwr_mem_wdata", bus.mem_wdata, 32'h12345678);
    @(negedge clock);
    check("lwr_ldr_ack", 32'(bus.ldr_ack), 32'h1);
    check("lwr_cpui_ack", 32'(bus.cpui_ack), 32'h0);
    @(negedge clock);

    // Loader read
    bus.ldr_request = 1'b1;
    bus.ldr_write   = 1'b0;
    bus.ldr_addr    = 32'h44;
    bus.ldr_wstrb   = 4'h0;
    @(negedge clock);
    bus.ldr_request = 1'b0;
    check("lrd_mem_write", 32'(bus.mem_write), 32'h0);
    @(negedge clock);
    check("lrd_ldr_ack", 32'(bus.ldr_ack), 32'h1);
    check("lrd_ldr_rdata", bus.ldr_rdata, 32'hDEADBFAB);
    @(negedge clock);

    // Both ports pulse together, twice: cpui then ldr each round
    for (int r = 0; r < 2; r++) begin
      bus.cpui_request = 1'b1;
      bus.cpui_addr    = 32'h500 + 32'(r) * 32'h10;
      bus.ldr_request  = 1'b1;
      bus.ldr_write    = 1'b0;
      bus.ldr_addr     = 32'h600 + 32'(r) * 32'h10;
      @(negedge clock);
      bus.cpui_request = 1'b0;
      bus.ldr_request  = 1'b0;
      n_c = 0;
      n_l = 0;
      first = 0;
      for (int c = 0; c < 12; c++) begin
        if (bus.cpui_ack) begin
          n_c++;
          if (first == 0) first = 1;
          check($sformatf("tie%0d_cpui_rdata", r), bus.cpui_rdata, mem_word(32'h500 + 32'(r) * 32'h10));
        end
        if (bus.ldr_ack) begin
          n_l++;
          if (first == 0) first = 2;
          check($sformatf("tie%0d_ldr_rdata", r), bus.ldr_rdata, mem_word(32'h600 + 32'(r) * 32'h10));
        end
        @(negedge clock);
      end
      check($sformatf("tie%0d_first_owner", r), first, 32'd1);
      check($sformatf("tie%0d_cpui_acks", r), n_c, 32'd1);
      check($sformatf("tie%0d_ldr_acks", r), n_l, 32'd1);
    end

    // Second CPU pulse before its ack is dropped and flagged
    mem_delay = 3;
    bus.cpui_request = 1'b1;
    bus.cpui_addr    = 32'h200;
    @(negedge clock);
    check("ovf_mem_addr", bus.mem_addr, 32'h200);
    check("ovf_err_before", 32'(bus.proto_err), 32'h0);
    bus.cpui_addr = 32'h204;
    @(negedge clock);
    bus.cpui_request = 1'b0;
    check("ovf_proto_err", 32'(bus.proto_err), 32'h1);
    n_c = 0;
    n_req = 0;
    for (int c = 0; c < 10; c++) begin
      if (bus.mem_request) n_req++;
      if (bus.cpui_ack) begin
        n_c++;
        check("ovf_rdata", bus.cpui_rdata, 32'hDEADBDEF);
      end
      @(negedge clock);
    end
    check("ovf_cpui_acks", n_c, 32'd1);
    check("ovf_extra_mem_req", n_req, 32'd0);

    // Reset while BUSY; the delayed ack that follows must be ignored
    bus.cpui_request = 1'b1;
    bus.cpui_addr    = 32'h300;
    @(negedge clock);
    bus.cpui_request = 1'b0;
    check("rbusy_mem_request", 32'(bus.mem_request), 32'h1);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("rbusy_async_mem_addr", bus.mem_addr, 32'h0);
    check("rbusy_async_proto_err", 32'(bus.proto_err), 32'h0);
    @(negedge clock);
    reset = 1'b1;
    n_c = 0;
    n_req = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      if (bus.cpui_ack || bus.ldr_ack) n_c++;
      if (bus.mem_request) n_req++;
    end
    check("rbusy_stale_acks", n_c, 32'd0);
    check("rbusy_no_mem_req", n_req, 32'd0);
    check("rbusy_proto_err", 32'(bus.proto_err), 32'h0);
    mem_delay = 1;
    bus.cpui_request = 1'b1;
    bus.cpui_addr    = 32'h304;
    @(negedge clock);
    bus.cpui_request = 1'b0;
    check("rbusy_idle_mem_request", 32'(bus.mem_request), 32'h1);
    @(negedge clock);
    check("rbusy_idle_ack", 32'(bus.cpui_ack), 32'h1);
    check("rbusy_idle_rdata", bus.cpui_rdata, 32'hDEADBCEB);
    @(negedge clock);

    // CPU pulse in the same cycle as its own ack is accepted
    bus.cpui_request = 1'b1;
    bus.cpui_addr    = 32'h400;
    @(negedge clock);
    bus.cpui_request = 1'b0;
    @(negedge clock);
    check("b2b_first_ack", 32'(bus.cpui_ack), 32'h1);
    check("b2b_first_rdata", bus.cpui_rdata, mem_word(32'h400));
    bus.cpui_request = 1'b1;
    bus.cpui_addr    = 32'h404;
    @(negedge clock);
    bus.cpui_request = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      if (bus.mem_request) seen = 1'b1;
      else @(negedge clock);
    end
    check("b2b_reissue", 32'(seen), 32'h1);
    check("b2b_mem_addr", bus.mem_addr, 32'h404);
    @(negedge clock);
    check("b2b_second_ack", 32'(bus.cpui_ack), 32'h1);
    check("b2b_second_rdata", bus.cpui_rdata, mem_word(32'h404));
    check("b2b_proto_err", 32'(bus.proto_err), 32'h0);
    @(negedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
